// File: rtl/hyperram_responder_if.sv
// HyperRAM link signals as seen from the emulated device.
// The controller modport carries the device-side directions used by hyperram_responder.
interface hyperram_responder_if;
  logic       cs;
  logic       ck;
  logic [7:0] din;
  logic [7:0] dout;
  logic       rwdsin;
  logic       rwdsout;
  logic       reset;

  modport controller (
    input  cs, ck, din, rwdsin, reset,
    output dout, rwdsout
  );
endinterface

// File: rtl/hyperram_responder.sv
// HyperRAM PSRAM emulator: decodes the 48-bit CA, counts latency and serves
// linear or wrapped 16-bit word bursts out of an on-chip array.
module hyperram_responder #(
  parameter int address_bus_width = 16,
  parameter int latency_cycles    = 6,
  parameter bit fixed_latency     = 1'b1,
  parameter int wrap_bytes        = 32
) (
  input logic                      clk,
  input logic                      rst,
  hyperram_responder_if.controller hyperram
);

  localparam int AW    = address_bus_width;
  localparam int LAT_N = 2 * latency_cycles * (fixed_latency ? 2 : 1);
  localparam int CW    = $clog2(LAT_N + 1);
  localparam int WB    = $clog2(wrap_bytes / 2);
  localparam logic [AW-1:0] WRAP_MASK = AW'((1 << WB) - 1);

  typedef enum logic [2:0] {IDLE, CA, LATENCY, READ, WRITE, REGWR} state_t;

  state_t         state;
  logic [39:0]    ca;
  logic [2:0]     ca_cnt;
  logic [CW-1:0]  lat_cnt;
  logic [AW-1:0]  addr;
  logic           is_read;
  logic           is_reg;
  logic           is_linear;
  logic           low_phase;
  logic [7:0]     hi_byte;
  logic           hi_mask;
  logic           hi_valid;
  logic [7:0]     dout_q;
  logic           rwdsout_q;

  logic [15:0]    mem [0:(1 << AW) - 1];
  logic [15:0]    rdata;

  logic           active;
  logic [47:0]    ca_next;
  logic [31:0]    ca_full;
  logic [AW-1:0]  next_addr;
  logic [AW-1:0]  rd_addr;
  logic [15:0]    rword;
  logic           commit;
  logic           ca_unused;

  assign active  = !hyperram.cs && hyperram.reset;
  assign ca_next = {ca, hyperram.din};
  assign ca_full = {ca_next[44:16], ca_next[2:0]};
  // Only the decoded CA fields are used; the reserved bits are folded away here.
  assign ca_unused = ^{ca_full, ca_next[15:3]};

  assign commit = active && (state == WRITE) && !hyperram.ck && hi_valid;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_addr = addr + AW'(1);
    if (!is_linear) next_addr = (addr & ~WRAP_MASK) | ((addr + AW'(1)) & WRAP_MASK);
    rd_addr = addr;
    if (state == READ && low_phase) rd_addr = next_addr;
    rword = rdata;
    if (is_reg) rword = (addr == '0) ? 16'h0C81 : 16'h0000;
  end

  // NOTE: the array is not reset; its contents survive both reset inputs.
  always_ff @(posedge clk) begin
    if (commit && !hi_mask)        mem[addr][15:8] <= hi_byte;
    if (commit && !hyperram.rwdsin) mem[addr][7:0] <= hyperram.din;
    rdata <= mem[rd_addr];
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ca        <= '0;
      ca_cnt    <= '0;
      lat_cnt   <= '0;
      addr      <= '0;
      is_read   <= 1'b0;
      is_reg    <= 1'b0;
      is_linear <= 1'b0;
      low_phase <= 1'b0;
      hi_byte   <= '0;
      hi_mask   <= 1'b0;
      hi_valid  <= 1'b0;
      dout_q    <= '0;
      rwdsout_q <= 1'b0;
    end else if (!active) begin
      state     <= IDLE;
      hi_valid  <= 1'b0;
      dout_q    <= '0;
      rwdsout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ca        <= ca_next[39:0];
          ca_cnt    <= 3'd1;
          state     <= CA;
          dout_q    <= '0;
          rwdsout_q <= fixed_latency;
        end
        CA: begin
          ca <= ca_next[39:0];
          if (ca_cnt == 3'd5) begin
            is_read   <= ca_next[47];
            is_reg    <= ca_next[46];
            is_linear <= ca_next[45];
            addr      <= ca_full[AW-1:0];
            rwdsout_q <= 1'b0;
            lat_cnt   <= CW'(LAT_N - 1);
            state     <= (!ca_next[47] && ca_next[46]) ? REGWR : LATENCY;
          end else begin
            ca_cnt    <= ca_cnt + 3'd1;
            rwdsout_q <= fixed_latency;
          end
        end
        LATENCY: begin
          if (lat_cnt == '0) begin
            state     <= is_read ? READ : WRITE;
            low_phase <= 1'b0;
            hi_valid  <= 1'b0;
          end else begin
            lat_cnt <= lat_cnt - CW'(1);
          end
        end
        READ: begin
          low_phase <= !low_phase;
          if (!low_phase) begin
            dout_q    <= rword[15:8];
            rwdsout_q <= 1'b1;
          end else begin
            dout_q    <= rword[7:0];
            rwdsout_q <= 1'b0;
            addr      <= next_addr;
          end
        end
        WRITE: begin
          if (hyperram.ck) begin
            hi_byte  <= hyperram.din;
            hi_mask  <= hyperram.rwdsin;
            hi_valid <= 1'b1;
          end else if (hi_valid) begin
            hi_valid <= 1'b0;
            addr     <= next_addr;
          end
        end
        REGWR: ;
        default: state <= IDLE;
      endcase
    end
  end

  assign hyperram.dout    = dout_q;
  assign hyperram.rwdsout = rwdsout_q;

endmodule

// File: tb/tb_hyperram_responder.sv
// Randomized self-checking bench for hyperram_responder against an array-based
// model of the HyperRAM word space; a second instance covers 1x latency.
module tb_hyperram_responder;

  localparam int N_FIX = 24;
  localparam int N_VAR = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hyperram_responder_if hr ();
  hyperram_responder_if hr0 ();

  hyperram_responder #(.address_bus_width(16), .latency_cycles(6),
                       .fixed_latency(1'b1), .wrap_bytes(32))
    dut (.clk(clk), .rst(rst), .hyperram(hr));

  hyperram_responder #(.address_bus_width(16), .latency_cycles(6),
                       .fixed_latency(1'b0), .wrap_bytes(32))
    dut0 (.clk(clk), .rst(rst), .hyperram(hr0));

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] model [int];
  logic [15:0] exp_q [$];
  logic [15:0] wr_q  [$];
  logic [1:0]  msk_q [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [8:0] out(input bit w);
    return w ? {hr0.rwdsout, hr0.dout} : {hr.rwdsout, hr.dout};
  endfunction

  function automatic int step_addr(input int a, input bit lin);
    if (lin) return (a + 1) % 65536;
    return (a / 16) * 16 + (a + 1) % 16;
  endfunction

  function automatic logic [15:0] model_rd(input int a);
    return model.exists(a) ? model[a] : 16'h0000;
  endfunction

  task automatic drive(input bit w, input logic cs, input logic ck, input logic [7:0] d, input logic m);
    if (w) begin
      hr0.cs = cs; hr0.ck = ck; hr0.din = d; hr0.rwdsin = m;
    end else begin
      hr.cs = cs; hr.ck = ck; hr.din = d; hr.rwdsin = m;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_ca(input bit w, input bit rd, input bit rg, input bit lin, input logic [31:0] a);
    logic [47:0] ca;
    ca = {rd, rg, lin, a[31:3], 13'h0000, a[2:0]};
    for (int i = 0; i < 6; i++) begin
      drive(w, 1'b0, (i % 2 == 0), ca[47 - 8*i -: 8], 1'b0);
      tick();
      if (i < 5) check("ca_rwds", {8'h0, out(w)} >> 8, w ? 32'd0 : 32'd1);
    end
  endtask

  task automatic wait_latency(input bit w);
    int n;
    n = w ? N_VAR : N_FIX;
    for (int k = 1; k <= n; k++) begin
      drive(w, 1'b0, k[0], 8'h00, 1'b0);
      tick();
    end
    check("lat_quiet", out(w), 0);
  endtask

  task automatic end_burst(input bit w);
    drive(w, 1'b1, 1'b0, 8'h00, 1'b0);
    tick();
    check("cs_idle", out(w), 0);
  endtask

  task automatic write_burst(input int a, input bit lin);
    logic [15:0] old;
    int addr;
    send_ca(1'b0, 1'b0, 1'b0, lin, a);
    wait_latency(1'b0);
    addr = a;
    foreach (wr_q[j]) begin
      drive(1'b0, 1'b0, 1'b1, wr_q[j][15:8], msk_q[j][1]);
      tick();
      drive(1'b0, 1'b0, 1'b0, wr_q[j][7:0], msk_q[j][0]);
      tick();
      old = model_rd(addr);
      model[addr] = {msk_q[j][1] ? old[15:8] : wr_q[j][15:8],
                     msk_q[j][0] ? old[7:0]  : wr_q[j][7:0]};
      addr = step_addr(addr, lin);
    end
    end_burst(1'b0);
    wr_q.delete();
    msk_q.delete();
  endtask

  // Expected words come from exp_q when it is filled, otherwise from the model.
  task automatic read_burst(input bit w, input bit rg, input bit lin, input int a,
                            input int nwords, input string tag);
    logic [15:0] e;
    int addr;
    send_ca(w, 1'b1, rg, lin, a);
    wait_latency(w);
    addr = a;
    for (int j = 0; j < nwords; j++) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else if (rg) e = (addr == 0) ? 16'h0C81 : 16'h0000;
      else e = model_rd(addr);
      drive(w, 1'b0, 1'b1, 8'h00, 1'b0);
      tick();
      check(tag, out(w), {1'b1, e[15:8]});
      drive(w, 1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      check(tag, out(w), {1'b0, e[7:0]});
      addr = step_addr(addr, lin);
    end
    end_burst(w);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base, len;
    bit lin;
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    hr.reset = 1'b1;
    hr0.reset = 1'b1;
    tick();
    tick();
    check("reset_out", out(1'b0), 0);
    check("reset_out0", out(1'b1), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 256; i++) begin wr_q.push_back(16'($urandom)); msk_q.push_back(2'b00); end
    write_burst(32'h100, 1'b1);
    for (int i = 0; i < 16; i++) begin wr_q.push_back(16'($urandom)); msk_q.push_back(2'b00); end
    write_burst(32'h10, 1'b1);

    wr_q = '{16'h1234, 16'h5678};
    msk_q = '{2'b00, 2'b00};
    write_burst(32'h10, 1'b1);
    exp_q = '{16'h1234, 16'h5678};
    read_burst(1'b0, 1'b0, 1'b1, 32'h10, 2, "lin_rd");

    exp_q = '{model_rd(32'h1E), model_rd(32'h1F), model_rd(32'h10), model_rd(32'h11)};
    read_burst(1'b0, 1'b0, 1'b0, 32'h1E, 4, "wrap_rd");

    wr_q = '{16'h0000, 16'h4321};
    msk_q = '{2'b00, 2'b00};
    write_burst(32'h20, 1'b1);
    wr_q = '{16'hAABB};
    msk_q = '{2'b10};
    write_burst(32'h20, 1'b1);
    exp_q = '{16'h00BB};
    read_burst(1'b0, 1'b0, 1'b1, 32'h20, 1, "mask_rd");

    // Abandoned write: only the high byte goes out before CS rises.
    send_ca(1'b0, 1'b0, 1'b0, 1'b1, 32'h21);
    wait_latency(1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
    tick();
    end_burst(1'b0);
    exp_q = '{16'h4321};
    read_burst(1'b0, 1'b0, 1'b1, 32'h21, 1, "partial_rd");

    send_ca(1'b0, 1'b1, 1'b0, 1'b1, 32'h10);
    wait_latency(1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    check("pre_rst_byte", out(1'b0), {1'b1, 8'h12});
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
    #1;
    check("rst_async", out(1'b0), 0);
    tick();
    check("rst_idle", out(1'b0), 0);
    rst = 1'b0;
    exp_q = '{16'h1234, 16'h5678};
    read_burst(1'b0, 1'b0, 1'b1, 32'h10, 2, "post_rst_rd");

    send_ca(1'b0, 1'b1, 1'b0, 1'b1, 32'h10);
    wait_latency(1'b0);
    drive(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
    tick();
    hr.reset = 1'b0;
    tick();
    check("dev_reset", out(1'b0), 0);
    hr.reset = 1'b1;
    end_burst(1'b0);

    exp_q = '{16'h0C81, 16'h0000};
    read_burst(1'b0, 1'b1, 1'b1, 32'h0, 2, "reg_rd");
    exp_q = '{16'h0C81};
    read_burst(1'b1, 1'b1, 1'b1, 32'h0, 1, "reg_rd_1x");

    for (int r = 0; r < 16; r++) begin
      lin  = 1'($urandom_range(0, 1));
      base = 32'h100 + int'($urandom_range(0, 32'hF0));
      len  = int'($urandom_range(1, 8));
      for (int i = 0; i < len; i++) begin
        wr_q.push_back(16'($urandom));
        msk_q.push_back({$urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0});
      end
      write_burst(base, lin);
      read_burst(1'b0, 1'b0, lin, base, len + int'($urandom_range(0, 2)), "rand_rd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
